cbrt_feeder: RTL and testbench
==============================

CBRT_FEEDER -- requirements
Module: cbrt_feeder

Interface
REQ-001 Parameter: DEPTH, 4, operand FIFO depth; power of two, 2..16.
REQ-002 Parameter: DATA_W, 8, operand/result width; matches root core port width.
REQ-003 Port: clk  in  1  clock; all logic on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  in  1  operand offered by upstream.
REQ-006 Port: in_data  in  DATA_W  operand value.
REQ-007 Port: in_ready  out  1  feeder accepts operand this cycle.
REQ-008 Port: res_valid  out  1  result held for downstream.
REQ-009 Port: res_data  out  DATA_W  integer cube root of the operand.
REQ-010 Port: res_ready  in  1  downstream accepts result.
REQ-011 Port: core_start  out  1  one-cycle start pulse to root core.
REQ-012 Port: core_x  out  DATA_W  operand to root core; stable from start until core idle again.
REQ-013 Port: core_busy  in  1  root core busy flag.
REQ-014 Port: core_y  in  DATA_W  root core result; valid when core_busy falls.
REQ-015 Port: jobs_done  out  8  count of results handed downstream; wraps 255->0.

Function
REQ-016 Operand transfer on in_valid&&in_ready; in_ready SHALL equal !fifo_full (no same-cycle pass-through when full).
REQ-017 Result transfer on res_valid&&res_ready; res_data/res_valid SHALL hold stable while res_valid&&!res_ready.
REQ-018 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUT.
REQ-019 IDLE: FIFO non-empty -> pop head into core_x register, go ISSUE next cycle.
REQ-020 ISSUE: core_start=1 for exactly one cycle, -> WAIT_BUSY.
REQ-021 WAIT_BUSY: stay until core_busy=1, then -> WAIT_DONE; core_start stays 0.
REQ-022 WAIT_DONE: on core_busy=0, capture core_y into res_data, res_valid=1, -> OUT.
REQ-023 OUT: on res_ready, res_valid=0, jobs_done+1, -> IDLE; new job issue earliest next cycle.
REQ-024 Results SHALL appear in operand arrival order; exactly one result per operand.
REQ-025 Minimum latency operand-accept to res_valid: 4 cycles plus core compute time.
REQ-026 Simultaneous push and pop on the same cycle SHALL both occur; FIFO count unchanged.
REQ-027 FIFO pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-028 Operand 0 and 255 SHALL be handled like any other value (no special-casing).

Reset
REQ-029 On rst: state=IDLE, FIFO emptied, in_ready=1 next cycle, res_valid=0, res_data=0, core_start=0, core_x=0, jobs_done=0.
REQ-030 rst mid-job SHALL discard the in-flight job and all queued operands; no result emitted for them.

Configuration
REQ-031 Macro CBRT_FEEDER_ECHO_EN defined: extra output res_x (DATA_W) carries the operand of the current result, same timing as res_data.
REQ-032 Macro undefined: res_x port absent; no operand storage beyond core_x.

Structure
REQ-033 Package cbrt_pkg SHALL hold DATA_W default and the FSM state enum typedef.
REQ-034 Operand queue SHALL be sub-module sync_fifo (DEPTH, DATA_W params, push/pop/full/empty/count).

Verification
REQ-035 Push 27, res_ready=1 -> single res_valid with res_data=3, jobs_done=1.
REQ-036 Back-to-back push 8,64,125,1 -> results 2,4,5,1 in order, jobs_done=4.
REQ-037 res_ready=0, push continuously, DEPTH=4 -> exactly 5 operands accepted, then in_ready=0; release res_ready -> all 5 results drain in order.
REQ-038 Push 0 and 255 -> results 0 and 6.
REQ-039 Assert rst during WAIT_DONE with 2 queued -> no res_valid afterwards, in_ready=1, jobs_done=0.
REQ-040 With CBRT_FEEDER_ECHO_EN, push 64 -> res_data=4, res_x=64 in same cycle.

Source files
------------

// File: rtl/cbrt_pkg.sv
// Shared definitions for the cube-root feeder: default datapath width and FSM state type.
package cbrt_pkg;

  localparam int CBRT_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_OUT       = 3'd4
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous operand queue with occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally.
module sync_fifo
  import cbrt_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter int  DATA_W = CBRT_DATA_W,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s, do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == CNT_W'(0));
  assign count     = count_q;
  assign pop_data  = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Next pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; the count gates every read
  always_ff @(posedge clk) begin
    if (!rst && do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/cbrt_feeder.sv
// Feeds queued operands one at a time to an external cube-root core and hands
// results downstream in order. Optional CBRT_FEEDER_ECHO_EN adds res_x (operand echo).
module cbrt_feeder
  import cbrt_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = CBRT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic              core_start,
  output logic [DATA_W-1:0] core_x,
  input  logic              core_busy,
  input  logic [DATA_W-1:0] core_y,
  output logic [7:0]        jobs_done
`ifdef CBRT_FEEDER_ECHO_EN
  , output logic [DATA_W-1:0] res_x
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  state_e            state_q, state_d;
  logic              core_start_q, core_start_d;
  logic [DATA_W-1:0] core_x_q, core_x_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [7:0]        jobs_done_q, jobs_done_d;
`ifdef CBRT_FEEDER_ECHO_EN
  logic [DATA_W-1:0] res_x_q, res_x_d;
`endif

  logic              fifo_pop_s, fifo_full_s, fifo_empty_s, fifo_has_data_s;
  logic [DATA_W-1:0] fifo_data_s;
  logic [CNT_W-1:0]  fifo_count_s;

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // A job is issued only when flag and count agree the queue holds data
  assign fifo_has_data_s = !fifo_empty_s && (fifo_count_s != CNT_W'(0));

  assign in_ready   = !fifo_full_s;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign core_start = core_start_q;
  assign core_x     = core_x_q;
  assign jobs_done  = jobs_done_q;
`ifdef CBRT_FEEDER_ECHO_EN
  assign res_x      = res_x_q;
`endif

  // Job sequencing: pop, start pulse, wait for busy rise and fall, hold result
  always_comb begin
    state_d      = state_q;
    core_start_d = 1'b0;
    core_x_d     = core_x_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    jobs_done_d  = jobs_done_q;
    fifo_pop_s   = 1'b0;
`ifdef CBRT_FEEDER_ECHO_EN
    res_x_d      = res_x_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fifo_has_data_s) begin
          fifo_pop_s   = 1'b1;
          core_x_d     = fifo_data_s;
          core_start_d = 1'b1;
          state_d      = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (core_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!core_busy) begin
          res_data_d  = core_y;
          res_valid_d = 1'b1;
`ifdef CBRT_FEEDER_ECHO_EN
          res_x_d     = core_x_q;
`endif
          state_d     = ST_OUT;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          jobs_done_d = jobs_done_q + 8'd1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      core_start_q <= 1'b0;
      core_x_q     <= DATA_W'(0);
      res_valid_q  <= 1'b0;
      res_data_q   <= DATA_W'(0);
      jobs_done_q  <= 8'd0;
`ifdef CBRT_FEEDER_ECHO_EN
      res_x_q      <= DATA_W'(0);
`endif
    end else begin
      state_q      <= state_d;
      core_start_q <= core_start_d;
      core_x_q     <= core_x_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      jobs_done_q  <= jobs_done_d;
`ifdef CBRT_FEEDER_ECHO_EN
      res_x_q      <= res_x_d;
`endif
    end
  end

endmodule

// File: tb/tb_cbrt_feeder.sv
// Self-checking bench for cbrt_feeder: behavioural root core plus an in-order
// scoreboard of accepted operands and their integer cube roots.
module tb_cbrt_feeder;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, res_valid, res_ready;
  logic              core_start, core_busy;
  logic [DATA_W-1:0] in_data, res_data, core_x, core_y;
  logic [7:0]        jobs_done;
`ifdef CBRT_FEEDER_ECHO_EN
  logic [DATA_W-1:0] res_x;
`endif

  cbrt_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .core_start (core_start),
    .core_x     (core_x),
    .core_busy  (core_busy),
    .core_y     (core_y),
    .jobs_done  (jobs_done)
`ifdef CBRT_FEEDER_ECHO_EN
    , .res_x    (res_x)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int first_valid_cyc = -1;
  int acc_cyc = -1;
  bit last_acc, seen_valid, rr_rand, long_comp;
  logic [7:0] acc_q[$], got_q[$], gotx_q[$], stim_q[$];

  // Largest r with r^3 <= x
  function automatic int cbrt_ref(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Behavioural root core: random start delay and compute time, garbage y while busy
  logic [7:0] core_op;
  int core_dly, core_comp;
  initial begin
    core_busy = 1'b0;
    core_y    = 8'd0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        core_op  = core_x;
        core_dly = $urandom_range(0, 2);
        repeat (core_dly) @(negedge clk);
        core_busy = 1'b1;
        core_y    = 8'($urandom);
        core_comp = long_comp ? 25 : $urandom_range(2, 5);
        repeat (core_comp) @(negedge clk);
        core_y    = 8'(cbrt_ref(int'(core_op)));
        core_busy = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: observe handshakes at negedge, return just after the next posedge
  task automatic cycle();
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      acc_q.push_back(in_data);
      if (acc_cyc < 0) acc_cyc = cyc;
    end
    if (res_valid) begin
      seen_valid = 1'b1;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (res_valid && res_ready) begin
      got_q.push_back(res_data);
`ifdef CBRT_FEEDER_ECHO_EN
      gotx_q.push_back(res_x);
`endif
    end
    cyc++;
    @(posedge clk);
    #1;
    if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic apply_reset();
    int t = 0;
    in_valid = 1'b0; res_ready = 1'b0; rr_rand = 1'b0; long_comp = 1'b0;
    while (core_busy && t < 100) begin cycle(); t++; end
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    acc_q.delete(); got_q.delete(); gotx_q.delete(); stim_q.delete();
    seen_valid = 1'b0; first_valid_cyc = -1; acc_cyc = -1;
  endtask

  task automatic send_all(input int budget, input bit gaps);
    int t = 0;
    while (stim_q.size() > 0 && t < budget) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = stim_q[0];
      end
      cycle();
      if (last_acc) void'(stim_q.pop_front());
      t++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int t = 0;
    while (got_q.size() < n && t < budget) begin cycle(); t++; end
    if (got_q.size() < n) begin
      vectors++; miscompares++;
      $display("FAIL wait_results: got %0d results, required %0d within %0d cycles",
               got_q.size(), n, budget);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; res_ready = 1'b0; in_data = 8'd0; rr_rand = 1'b0; long_comp = 1'b0;
    rst = 1'b1;
    cycle(); cycle();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    vectors++; if (res_data !== 8'd0) begin miscompares++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
    vectors++; if (core_start !== 1'b0) begin miscompares++; $display("FAIL reset_core_start: got %b want 0", core_start); end
    vectors++; if (core_x !== 8'd0) begin miscompares++; $display("FAIL reset_core_x: got %0d want 0", core_x); end
    vectors++; if (jobs_done !== 8'd0) begin miscompares++; $display("FAIL reset_jobs_done: got %0d want 0", jobs_done); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    res_ready = 1'b1;
    stim_q.push_back(8'd27);
    send_all(20, 1'b0);
    wait_results(1, 100);
    repeat (10) cycle();
    vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d results want 1", got_q.size()); end
    vectors++; if (got_q.size() < 1 || got_q[0] !== 8'd3) begin miscompares++; $display("FAIL single_value: got %0d want 3", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    vectors++; if (jobs_done !== 8'd1) begin miscompares++; $display("FAIL single_jobs_done: got %0d want 1", jobs_done); end
    vectors++; if (first_valid_cyc - acc_cyc < 5) begin miscompares++; $display("FAIL single_latency: got %0d samples want >= 5", first_valid_cyc - acc_cyc); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    exp_q = '{8'd2, 8'd4, 8'd5, 8'd1};
    apply_reset();
    res_ready = 1'b1;
    stim_q = '{8'd8, 8'd64, 8'd125, 8'd1};
    send_all(40, 1'b0);
    wait_results(4, 200);
    repeat (10) cycle();
    vectors++; if (got_q.size() != 4) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_value[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (jobs_done !== 8'd4) begin miscompares++; $display("FAIL b2b_jobs_done: got %0d want 4", jobs_done); end
  endtask

  task automatic test_fill_stall();
    bit held = 1'b0;
    logic [7:0] hold_val = 8'd0;
    apply_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      cycle();
      if (res_valid) begin
        if (!held) begin
          held = 1'b1; hold_val = res_data;
        end else begin
          vectors++;
          if (res_data !== hold_val) begin miscompares++; $display("FAIL stall_hold_data: got %0d want %0d", res_data, hold_val); end
        end
      end else if (held) begin
        vectors++; miscompares++;
        $display("FAIL stall_hold_valid: got 0 want 1");
      end
    end
    in_valid = 1'b0;
    vectors++; if (acc_q.size() != DEPTH + 1) begin miscompares++; $display("FAIL stall_accepted: got %0d want %0d", acc_q.size(), DEPTH + 1); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    res_ready = 1'b1;
    wait_results(DEPTH + 1, 300);
    repeat (20) cycle();
    vectors++; if (got_q.size() != acc_q.size()) begin miscompares++; $display("FAIL stall_drain_count: got %0d want %0d", got_q.size(), acc_q.size()); end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== 8'(cbrt_ref(int'(acc_q[i])))) begin miscompares++; $display("FAIL stall_value[%0d]: got %0d want %0d", i, got_q[i], cbrt_ref(int'(acc_q[i]))); end
    end
    vectors++; if (jobs_done !== 8'd5) begin miscompares++; $display("FAIL stall_jobs_done: got %0d want 5", jobs_done); end
  endtask

  task automatic test_extremes();
    apply_reset();
    res_ready = 1'b1;
    stim_q = '{8'd0, 8'd255};
    send_all(20, 1'b0);
    wait_results(2, 100);
    vectors++; if (got_q.size() < 1 || got_q[0] !== 8'd0) begin miscompares++; $display("FAIL extreme_zero: got %0d want 0", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    vectors++; if (got_q.size() < 2 || got_q[1] !== 8'd6) begin miscompares++; $display("FAIL extreme_255: got %0d want 6", (got_q.size() > 1) ? got_q[1] : 8'hxx); end
  endtask

  task automatic test_random();
    apply_reset();
    res_ready = 1'b1;
    rr_rand = 1'b1;
    for (int i = 0; i < 260; i++) stim_q.push_back(8'($urandom));
    send_all(6000, 1'b1);
    wait_results(260, 3000);
    rr_rand = 1'b0;
    res_ready = 1'b1;
    repeat (20) cycle();
    vectors++; if (got_q.size() != 260 || acc_q.size() != 260) begin miscompares++; $display("FAIL random_count: got %0d results for %0d operands want 260", got_q.size(), acc_q.size()); end
    for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== 8'(cbrt_ref(int'(acc_q[i])))) begin miscompares++; $display("FAIL random_value[%0d]: got %0d want %0d", i, got_q[i], cbrt_ref(int'(acc_q[i]))); end
`ifdef CBRT_FEEDER_ECHO_EN
      vectors++;
      if (gotx_q[i] !== acc_q[i]) begin miscompares++; $display("FAIL random_echo[%0d]: got %0d want %0d", i, gotx_q[i], acc_q[i]); end
`endif
    end
    vectors++; if (jobs_done !== 8'd4) begin miscompares++; $display("FAIL random_jobs_wrap: got %0d want 4", jobs_done); end
  endtask

  task automatic test_reset_mid_job();
    int t = 0;
    apply_reset();
    res_ready = 1'b1;
    long_comp = 1'b1;
    stim_q = '{8'd27, 8'd64, 8'd125};
    send_all(20, 1'b0);
    while (!core_busy && t < 20) begin cycle(); t++; end
    vectors++; if (core_busy !== 1'b1) begin miscompares++; $display("FAIL midjob_core_started: got %b want 1", core_busy); end
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    long_comp = 1'b0;
    seen_valid = 1'b0;
    got_q.delete();
    repeat (40) cycle();
    vectors++; if (seen_valid !== 1'b0) begin miscompares++; $display("FAIL midjob_res_valid: got 1 want 0"); end
    vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL midjob_results: got %0d want 0", got_q.size()); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midjob_in_ready: got %b want 1", in_ready); end
    vectors++; if (jobs_done !== 8'd0) begin miscompares++; $display("FAIL midjob_jobs_done: got %0d want 0", jobs_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_stall();
    test_extremes();
    test_random();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
